// File: rtl/wave_cap_pkg.sv
// Shared types and default geometry for the triggered waveform capture buffer.
package wave_cap_pkg;

  localparam int WCAP_DATA_W  = 11;
  localparam int WCAP_ADDR_W  = 10;
  localparam int WCAP_DEPTH   = 1 << WCAP_ADDR_W;
  localparam int WCAP_PRETRIG = 256;
  localparam int WCAP_AUTO_TO = 65000;
  localparam int WCAP_HDE_OFS = 296;

  // Write-side capture state
  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_TRIG = 2'd1,
    POST      = 2'd2,
    DONE      = 2'd3
  } cap_state_t;

endpackage : wave_cap_pkg

// File: rtl/wave_ram.sv
// Ping-pong sample store: two banks of DEPTH words selected by the address MSB.
// One write port and one registered read port, so it maps onto block RAM.
module wave_ram
  import wave_cap_pkg::*;
#(
  parameter int DATA_W = WCAP_DATA_W,
  parameter int ADDR_W = WCAP_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int WORDS = 2 << ADDR_W;

  logic [DATA_W-1:0] mem [0:WORDS-1];

  // Capture-side write into the bank currently being filled
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read for the display side
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule : wave_ram

// File: rtl/wave_capture_buffer.sv
// Triggered waveform capture for the VGA line renderer. One bank records a
// pre/post-trigger window while the other, frozen, bank is replayed one sample
// per pixel clock. Banks swap only at frame end so a frame never tears.
module wave_capture_buffer
  import wave_cap_pkg::*;
#(
  parameter int DATA_W  = WCAP_DATA_W,
  parameter int ADDR_W  = WCAP_ADDR_W,
  parameter int PRETRIG = WCAP_PRETRIG,
  parameter int AUTO_TO = WCAP_AUTO_TO,
  parameter int HDE_OFS = WCAP_HDE_OFS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              auto_en,
  input  logic              vga_hs,
  input  logic              memory_ack,
  output logic [DATA_W-1:0] memory_data,
  output logic              trig_seen,
  output logic              bank_ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = $clog2(AUTO_TO);
  localparam int COL_W = $clog2(HDE_OFS + DEPTH + 2) + 1;

  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 2);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] HDE_A     = ADDR_W'(HDE_OFS);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TO - 1);
  localparam logic [COL_W-1:0]  WIN_LO    = COL_W'(HDE_OFS);
  localparam logic [COL_W-1:0]  WIN_HI    = COL_W'(HDE_OFS + DEPTH);

  // Rising crossing of the threshold between consecutive valid samples
  function automatic logic rising_cross(input logic [DATA_W-1:0] prev,
                                        input logic [DATA_W-1:0] cur,
                                        input logic [DATA_W-1:0] lvl);
    return (prev < lvl) && (cur >= lvl);
  endfunction

  cap_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] rd_start;
  logic              rd_bank;
  logic              wr_bank;
  logic              first_swap;
  logic              ack_q;
  logic [DATA_W-1:0] prev_sample;

  logic              swap;
  logic              fire;
  logic              wr_en;

  logic              hs_q;
  logic              hs_fall;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_ahead;
  logic              in_win;

  logic [ADDR_W-1:0] rd_addr_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p2;
  logic              vld_p2;

  // Frame end is the falling edge of memory_ack; only a finished record swaps in
  assign swap = ack_q && !memory_ack && (state == DONE);

  // A late auto_en still fires at once because the timeout compare is >=
  assign fire = rising_cross(prev_sample, sample_data, trig_level) ||
                (auto_en && (to_cnt >= TO_LAST));

  // A strobe that coincides with a swap is dropped; DONE never writes
  assign wr_en = sample_valid && !swap && (state != DONE);

  // Write-side capture FSM with its counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      wr_ptr     <= '0;
      cnt        <= '0;
      to_cnt     <= '0;
      trig_addr  <= '0;
      rd_start   <= '0;
      rd_bank    <= 1'b0;
      wr_bank    <= 1'b1;
      first_swap <= 1'b0;
      ack_q      <= 1'b0;
      trig_seen  <= 1'b0;
      bank_ready <= 1'b0;
    end else begin
      ack_q     <= memory_ack;
      trig_seen <= 1'b0;
      if (swap) begin
        rd_bank    <= wr_bank;
        wr_bank    <= rd_bank;
        rd_start   <= trig_addr - PRE_OFS;
        bank_ready <= 1'b0;
        state      <= FILL;
        wr_ptr     <= '0;
        cnt        <= '0;
        first_swap <= 1'b1;
      end else if (sample_valid) begin
        case (state)
          FILL: begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (cnt == PRE_LAST) begin
              cnt    <= '0;
              to_cnt <= '0;
              state  <= WAIT_TRIG;
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
          WAIT_TRIG: begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (fire) begin
              trig_addr <= wr_ptr;
              trig_seen <= 1'b1;
              cnt       <= '0;
              state     <= POST;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          POST: begin
            // The trigger sample already counted as the first post write
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (cnt == POST_LAST) begin
              state      <= DONE;
              bank_ready <= 1'b1;
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
          DONE: begin
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  // Last valid sample, the left-hand side of the crossing compare
  always_ff @(posedge clk) begin
    if (sample_valid) begin
      prev_sample <= sample_data;
    end
  end

  wave_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr({wr_bank, wr_ptr}),
    .wr_data(sample_data),
    .rd_addr({rd_bank, rd_addr_p0}),
    .rd_data(rd_data_p1)
  );

  assign hs_fall = hs_q && !vga_hs;

  // Pixel column counter, restarted by each hsync falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b1;
      col  <= '0;
    end else begin
      hs_q <= vga_hs;
      col  <= hs_fall ? '0 : col + COL_W'(1);
    end
  end

  // Stage p0: address two columns ahead to cover RAM and output register latency
  assign col_ahead  = col + COL_W'(2);
  assign in_win     = (col_ahead >= WIN_LO) && (col_ahead < WIN_HI);
  assign rd_addr_p0 = rd_start + col_ahead[ADDR_W-1:0] - HDE_A;
  assign vld_p0     = memory_ack && first_swap && in_win;

  // Valid flag travelling with the read data through stages p1 and p2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p1 -> p2: output data register
  always_ff @(posedge clk) begin
    data_p2 <= rd_data_p1;
  end

  // Stage p2: blank outside the window, outside the frame and before any swap
  assign memory_data = vld_p2 ? data_p2 : '0;

endmodule : wave_capture_buffer

// File: tb/tb_wave_capture_buffer.sv
// Directed bench for wave_capture_buffer: capture records, frame-end swaps and
// column playback compared against hand-computed values.
module tb_wave_capture_buffer;

  localparam int DATA_W = 11;
  localparam int LINE_N = 1330;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [DATA_W-1:0] trig_level;
  logic              auto_en;
  logic              vga_hs;
  logic              memory_ack;
  logic [DATA_W-1:0] memory_data;
  logic              trig_seen;
  logic              bank_ready;

  wave_capture_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .trig_level  (trig_level),
    .auto_en     (auto_en),
    .vga_hs      (vga_hs),
    .memory_ack  (memory_ack),
    .memory_data (memory_data),
    .trig_seen   (trig_seen),
    .bank_ready  (bank_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] line_buf [0:LINE_N-1];

  // n = column counter value at sampling; ramp/cnst = expected memory_data
  typedef struct {
    int                n;
    logic [DATA_W-1:0] ramp;
    logic [DATA_W-1:0] cnst;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One display line: hsync falls, then memory_data is sampled per column
  task automatic run_line();
    vga_hs = 1'b0;
    for (int n = 0; n < LINE_N; n++) begin
      tick();
      line_buf[n] = memory_data;
      if (n == 135) vga_hs = 1'b1;
    end
  endtask

  task automatic check_line(input string name, input bit use_const);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s col%0d", name, vecs[i].n), int'(line_buf[vecs[i].n]),
            use_const ? int'(vecs[i].cnst) : int'(vecs[i].ramp));
    end
  endtask

  // Columns from 2 on depend only on the current line
  task automatic check_zero_line(input string name);
    int nz;
    nz = 0;
    for (int n = 2; n < LINE_N; n++) begin
      if (line_buf[n] != '0) nz++;
    end
    check({name, " nonzero columns"}, nz, 0);
  endtask

  function automatic logic [DATA_W-1:0] rec_val(input int kind, input int k);
    case (kind)
      0: return DATA_W'(k);
      1: return DATA_W'(500);
      default: begin
        if (k < 255) return '0;
        if (k == 255) return DATA_W'(1500);
        return DATA_W'(k - 256);
      end
    endcase
  endfunction

  // Stream strobes back to back until bank_ready or the strobe budget runs out
  task automatic run_record(input int kind, input int max_k,
                            output int trig_k, output int trig_cnt, output int done_k);
    trig_k   = -1;
    trig_cnt = 0;
    done_k   = -1;
    for (int k = 0; k < max_k; k++) begin
      sample_valid = 1'b1;
      sample_data  = rec_val(kind, k);
      tick();
      if (trig_seen) begin
        trig_cnt++;
        if (trig_k < 0) trig_k = k;
      end
      if (bank_ready) begin
        done_k = k;
        break;
      end
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int tk, tc, dk;

    vecs = '{
      '{2,    11'd0,    11'd0},
      '{295,  11'd0,    11'd0},
      '{296,  11'd744,  11'd500},
      '{297,  11'd745,  11'd500},
      '{551,  11'd999,  11'd500},
      '{552,  11'd1000, 11'd500},
      '{575,  11'd1023, 11'd500},
      '{576,  11'd1024, 11'd500},
      '{1063, 11'd1511, 11'd500},
      '{1319, 11'd1767, 11'd500},
      '{1320, 11'd0,    11'd0},
      '{1325, 11'd0,    11'd0}
    };

    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    trig_level   = DATA_W'(1000);
    auto_en      = 1'b0;
    vga_hs       = 1'b1;
    memory_ack   = 1'b0;
    repeat (3) tick();
    check("reset memory_data", int'(memory_data), 0);
    check("reset trig_seen", int'(trig_seen), 0);
    check("reset bank_ready", int'(bank_ready), 0);
    rst = 1'b0;
    tick();

    // Ramp record completing while the frame is active
    memory_ack = 1'b1;
    run_record(0, 3000, tk, tc, dk);
    check("ramp trigger index", tk, 1000);
    check("ramp trigger count", tc, 1);
    check("ramp done index", dk, 1767);
    run_line();
    check_zero_line("pre-swap frame");
    check("bank_ready held in frame", int'(bank_ready), 1);
    memory_ack = 1'b0;
    tick();
    check("bank_ready after swap", int'(bank_ready), 0);
    tick();
    memory_ack = 1'b1;
    run_line();
    check_line("ramp", 1'b0);
    memory_ack = 1'b0;
    tick();

    // Constant input with auto trigger
    auto_en = 1'b1;
    run_record(1, 67000, tk, tc, dk);
    check("auto trigger index", tk, 65255);
    check("auto trigger count", tc, 1);
    check("auto done index", dk, 66022);
    auto_en    = 1'b0;
    memory_ack = 1'b1;
    tick();
    tick();
    // Frame end coincident with a strobe in DONE
    memory_ack   = 1'b0;
    sample_valid = 1'b1;
    sample_data  = DATA_W'(77);
    tick();
    sample_valid = 1'b0;
    check("bank_ready after coincident swap", int'(bank_ready), 0);
    memory_ack = 1'b1;
    run_line();
    check_line("const", 1'b1);
    memory_ack = 1'b0;
    tick();

    // Crossing on the final FILL strobe must be ignored
    run_record(2, 3000, tk, tc, dk);
    check("late-fill trigger index", tk, 1256);
    check("late-fill trigger count", tc, 1);
    check("late-fill done index", dk, 2023);
    memory_ack = 1'b1;
    tick();
    memory_ack = 1'b0;
    tick();

    // No auto trigger allowed: record never completes, frame end keeps display
    run_record(1, 1500, tk, tc, dk);
    check("no-auto trigger count", tc, 0);
    check("no-auto done index", dk, -1);
    check("no-auto bank_ready", int'(bank_ready), 0);
    memory_ack = 1'b1;
    tick();
    tick();
    memory_ack = 1'b0;
    tick();
    memory_ack = 1'b1;
    run_line();
    check_line("kept", 1'b0);

    // Reset while in POST, in the middle of an active line
    sample_valid = 1'b1;
    sample_data  = DATA_W'(1200);
    tick();
    check("post trigger pulse", int'(trig_seen), 1);
    repeat (10) tick();
    sample_valid = 1'b0;
    vga_hs = 1'b0;
    for (int n = 0; n < 700; n++) begin
      tick();
      if (n == 135) vga_hs = 1'b1;
      if (n == 600) begin
        check("display before reset", int'(memory_data), 1048);
        rst = 1'b1;
      end
      if (n == 601) begin
        check("memory_data in reset", int'(memory_data), 0);
        check("bank_ready in reset", int'(bank_ready), 0);
        check("trig_seen in reset", int'(trig_seen), 0);
      end
      if (n == 650) rst = 1'b0;
    end
    run_line();
    check_zero_line("post-reset frame");
    run_record(0, 3000, tk, tc, dk);
    check("rebuild trigger index", tk, 1000);
    check("rebuild done index", dk, 1767);
    memory_ack = 1'b0;
    tick();
    check("rebuild bank_ready after swap", int'(bank_ready), 0);
    memory_ack = 1'b1;
    run_line();
    check_line("rebuilt", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_wave_capture_buffer
